// File: rtl/present_sbox_layer_ctrl_if.sv
// S-box side bus of the PRESENT substitution-layer sequencer: three nibble
// shares out, eight bits of randomness out, three nibble shares back.
interface present_sbox_layer_ctrl_if;
  logic [3:0] sbox_in1;
  logic [3:0] sbox_in2;
  logic [3:0] sbox_in3;
  logic [7:0] sbox_r;
  logic [3:0] sbox_out1;
  logic [3:0] sbox_out2;
  logic [3:0] sbox_out3;

  modport master (
    output sbox_in1, sbox_in2, sbox_in3, sbox_r,
    input  sbox_out1, sbox_out2, sbox_out3
  );

  modport slave (
    input  sbox_in1, sbox_in2, sbox_in3, sbox_r,
    output sbox_out1, sbox_out2, sbox_out3
  );
endinterface

// File: rtl/present_sbox_layer_ctrl.sv
// Streams the 16 nibbles of a 3-share 64-bit state through one shared masked
// S-box pipeline and reassembles the returned nibbles into three result shares.
module present_sbox_layer_ctrl #(
  parameter int SBOX_LAT = 4,
  parameter int RND_OFS  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic [63:0]                       st1_i,
  input  logic [63:0]                       st2_i,
  input  logic [63:0]                       st3_i,
  input  logic [7:0]                        rnd_in_i,
  output logic                              rnd_req_o,
  present_sbox_layer_ctrl_if.master         sbox_if,
  output logic                              busy_o,
  output logic                              done_o,
  output logic [63:0]                       res1_o,
  output logic [63:0]                       res2_o,
  output logic [63:0]                       res3_o
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_e;

  state_e              state_q;
  logic [63:0]         sh1_q, sh2_q, sh3_q;
  logic [63:0]         res1_q, res2_q, res3_q;
  logic [3:0]          issue_q, cap_q;
  logic [SBOX_LAT-1:0] vld_q;
  logic                busy_q, done_q;

  logic                feed;
  logic [SBOX_LAT:0]   tap;
  logic                cap_en;

  // tap[k] is "a nibble entered the S-box k cycles ago"; randomness and
  // capture are both just taps of this one delay line.
  assign feed      = (state_q == FEED);
  assign tap       = {vld_q, feed};
  assign cap_en    = tap[SBOX_LAT];
  assign rnd_req_o = tap[RND_OFS];

  assign sbox_if.sbox_in1 = feed ? sh1_q[3:0] : 4'h0;
  assign sbox_if.sbox_in2 = feed ? sh2_q[3:0] : 4'h0;
  assign sbox_if.sbox_in3 = feed ? sh3_q[3:0] : 4'h0;
  assign sbox_if.sbox_r   = rnd_req_o ? rnd_in_i : 8'h00;

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign res1_o = res1_q;
  assign res2_o = res2_q;
  assign res3_o = res3_q;

  // NOTE: every register here uses <= so all of them see pre-edge values;
  // the datapath registers are reset too because an abort must leave res* at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh1_q   <= '0;
      sh2_q   <= '0;
      sh3_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      res3_q  <= '0;
      issue_q <= '0;
      cap_q   <= '0;
      vld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      vld_q  <= tap[SBOX_LAT-1:0];

      if (cap_en) begin
        res1_q[{cap_q, 2'b00} +: 4] <= sbox_if.sbox_out1;
        res2_q[{cap_q, 2'b00} +: 4] <= sbox_if.sbox_out2;
        res3_q[{cap_q, 2'b00} +: 4] <= sbox_if.sbox_out3;
        cap_q <= cap_q + 4'd1;
      end

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            sh1_q   <= st1_i;
            sh2_q   <= st2_i;
            sh3_q   <= st3_i;
            res1_q  <= '0;
            res2_q  <= '0;
            res3_q  <= '0;
            issue_q <= '0;
            cap_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= FEED;
          end
        end
        FEED: begin
          sh1_q   <= {4'h0, sh1_q[63:4]};
          sh2_q   <= {4'h0, sh2_q[63:4]};
          sh3_q   <= {4'h0, sh3_q[63:4]};
          issue_q <= issue_q + 4'd1;
          if (issue_q == 4'd15) state_q <= DRAIN;
        end
        DRAIN: begin
          if (cap_en && (cap_q == 4'd15)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// Bench for the substitution-layer sequencer: four instances at different
// S-box latencies, each fed by a behavioural S-box and checked against a timing model.
module tb_present_sbox_layer_ctrl;

  localparam int NI = 4;

  function automatic int lat_of(input int g);
    case (g)
      0: return 4;
      1: return 1;
      2: return 6;
      default: return 15;
    endcase
  endfunction

  function automatic int ofs_of(input int g);
    case (g)
      0: return 1;
      1: return 0;
      2: return 5;
      default: return 14;
    endcase
  endfunction

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [63:0] t;
    t = 64'hC56B90AD3EF84712;
    return t[(15 - int'(x)) * 4 +: 4];
  endfunction

  function automatic int clamp16(input int v);
    if (v < 0) return 0;
    if (v > 16) return 16;
    return v;
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rnd_in;
  logic        start  [NI];
  logic [63:0] st     [NI][3];
  int          mode   [NI];   // 0 delay line, 1 unmasked S-box, 2 masked S-box
  logic        rreq_w [NI];
  logic        busy_w [NI];
  logic        done_w [NI];
  logic [7:0]  sr_w   [NI];
  logic [11:0] sin_w  [NI];
  logic [63:0] res_w  [NI][3];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int LAT = lat_of(g);
    localparam int OFS = ofs_of(g);
    localparam int RI  = LAT - 1 - OFS;

    present_sbox_layer_ctrl_if sif ();

    present_sbox_layer_ctrl #(.SBOX_LAT(LAT), .RND_OFS(OFS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start[g]),
      .st1_i    (st[g][0]),
      .st2_i    (st[g][1]),
      .st3_i    (st[g][2]),
      .rnd_in_i (rnd_in),
      .rnd_req_o(rreq_w[g]),
      .sbox_if  (sif),
      .busy_o   (busy_w[g]),
      .done_o   (done_w[g]),
      .res1_o   (res_w[g][0]),
      .res2_o   (res_w[g][1]),
      .res3_o   (res_w[g][2])
    );

    assign sin_w[g] = {sif.sbox_in3, sif.sbox_in2, sif.sbox_in1};
    assign sr_w[g]  = sif.sbox_r;

    // Behavioural S-box: shares and randomness delayed, function applied at the end.
    logic [11:0] dp [LAT];
    logic [7:0]  rv [LAT];

    always @(posedge clk) begin
      dp[0] <= {sif.sbox_in3, sif.sbox_in2, sif.sbox_in1};
      rv[0] <= sif.sbox_r;
      for (int k = 1; k < LAT; k++) begin
        dp[k] <= dp[k-1];
        rv[k] <= rv[k-1];
      end
    end

    always_comb begin
      logic [3:0] x, y, r_lo, r_hi;
      x    = dp[LAT-1][3:0] ^ dp[LAT-1][7:4] ^ dp[LAT-1][11:8];
      y    = sbox4(x);
      r_lo = rv[RI][3:0];
      r_hi = rv[RI][7:4];
      sif.sbox_out1 = dp[LAT-1][3:0];
      sif.sbox_out2 = dp[LAT-1][7:4];
      sif.sbox_out3 = dp[LAT-1][11:8];
      if (mode[g] == 1) begin
        sif.sbox_out1 = y;
        sif.sbox_out2 = 4'h0;
        sif.sbox_out3 = 4'h0;
      end else if (mode[g] == 2) begin
        sif.sbox_out1 = y ^ r_lo ^ r_hi;
        sif.sbox_out2 = r_lo;
        sif.sbox_out3 = r_hi;
      end
    end
  end

  // Timing model: n_m is the cycle number within the current layer (-1 = idle),
  // cap_m the number of result nibbles that must already be visible.
  int          n_m   [NI];
  int          cap_m [NI];
  int          md_m  [NI];
  logic [63:0] st_m  [NI][3];

  always @(posedge clk or negedge rst_n) begin
    for (int g = 0; g < NI; g++) begin
      if (!rst_n) begin
        n_m[g]   <= -1;
        cap_m[g] <= 0;
      end else if (n_m[g] < 0) begin
        if (start[g]) begin
          n_m[g]   <= 1;
          cap_m[g] <= 0;
          md_m[g]  <= mode[g];
          for (int k = 0; k < 3; k++) st_m[g][k] <= st[g][k];
        end
      end else begin
        cap_m[g] <= clamp16(n_m[g] - lat_of(g));
        n_m[g]   <= (n_m[g] >= 17 + lat_of(g)) ? -1 : n_m[g] + 1;
      end
    end
  end

  function automatic logic [3:0] exp_nib(input int g, input int k, input int j);
    logic [3:0] x;
    x = st_m[g][0][4*j +: 4] ^ st_m[g][1][4*j +: 4] ^ st_m[g][2][4*j +: 4];
    if (md_m[g] == 0) return st_m[g][k][4*j +: 4];
    return (k == 0) ? sbox4(x) : 4'h0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic compare_all();
    for (int g = 0; g < NI; g++) begin
      int          n, lat, ofs;
      bit          rq;
      logic [11:0] es;
      logic [63:0] er [3];
      n   = n_m[g];
      lat = lat_of(g);
      ofs = ofs_of(g);
      rq  = (n >= 1 + ofs) && (n <= 16 + ofs);
      es  = 12'h0;
      if (n >= 1 && n <= 16)
        es = {st_m[g][2][4*(n-1) +: 4], st_m[g][1][4*(n-1) +: 4], st_m[g][0][4*(n-1) +: 4]};
      for (int k = 0; k < 3; k++) begin
        er[k] = '0;
        for (int j = 0; j < cap_m[g]; j++) er[k][4*j +: 4] = exp_nib(g, k, j);
      end
      check($sformatf("u%0d_busy", g), 64'(busy_w[g]), 64'(n >= 1 && n <= 16 + lat));
      check($sformatf("u%0d_done", g), 64'(done_w[g]), 64'(n == 17 + lat));
      check($sformatf("u%0d_rnd_req", g), 64'(rreq_w[g]), 64'(rq));
      check($sformatf("u%0d_sbox_r", g), 64'(sr_w[g]), rq ? 64'(rnd_in) : 64'd0);
      check($sformatf("u%0d_sbox_in", g), 64'(sin_w[g]), 64'(es));
      check($sformatf("u%0d_res_xor", g), res_w[g][0] ^ res_w[g][1] ^ res_w[g][2], er[0] ^ er[1] ^ er[2]);
      if (md_m[g] != 2)
        for (int k = 0; k < 3; k++)
          check($sformatf("u%0d_res%0d", g, k + 1), res_w[g][k], er[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1 rnd_in = 8'($urandom);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_zero(input int g, input string tag);
    check($sformatf("%s_busy", tag), 64'(busy_w[g]), 64'd0);
    check($sformatf("%s_done", tag), 64'(done_w[g]), 64'd0);
    check($sformatf("%s_rnd_req", tag), 64'(rreq_w[g]), 64'd0);
    check($sformatf("%s_sbox_r", tag), 64'(sr_w[g]), 64'd0);
    check($sformatf("%s_sbox_in", tag), 64'(sin_w[g]), 64'd0);
    for (int k = 0; k < 3; k++) check($sformatf("%s_res%0d", tag, k + 1), res_w[g][k], 64'd0);
  endtask

  // Runs until done (bounded); cyc ends as the cycle number of done relative
  // to the cycle in which the task was entered.
  task automatic run_layer(input int g, input bit hold, output int cyc, output int nb, output int nr);
    bit seen;
    cyc  = 0;
    nb   = 0;
    nr   = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      tick();
      cyc++;
      if (!hold) start[g] = 1'b0;
      nb += int'(busy_w[g]);
      nr += int'(rreq_w[g]);
      seen = done_w[g];
    end
    check($sformatf("u%0d_done_seen", g), 64'(seen), 64'd1);
  endtask

  task automatic rand_state(input int g);
    st[g][0] = {$urandom, $urandom};
    st[g][1] = {$urandom, $urandom};
    st[g][2] = {$urandom, $urandom};
  endtask

  initial begin
    int          cyc, nb, nr, ndone, dcyc;
    logic [63:0] t0, t1, t2;

    rst_n  = 1'b1;
    rnd_in = 8'h00;
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
      mode[g]  = 0;
      for (int k = 0; k < 3; k++) st[g][k] = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) check_zero(g, $sformatf("reset_u%0d", g));
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Unshared known-answer test
    mode[0]  = 1;
    st[0][0] = 64'h0123456789ABCDEF;
    st[0][1] = '0;
    st[0][2] = '0;
    start[0] = 1'b1;
    run_layer(0, 1'b0, cyc, nb, nr);
    check("kat_done_cycle", 64'(cyc), 64'd21);
    check("kat_busy_cycles", 64'(nb), 64'd20);
    check("kat_rnd_cycles", 64'(nr), 64'd16);
    check("kat_result", res_w[0][0] ^ res_w[0][1] ^ res_w[0][2], 64'hC56B90AD3EF84712);
    tick();

    // Masked known-answer test: shares XOR to zero
    mode[0]  = 2;
    st[0][1] = {$urandom, $urandom};
    st[0][2] = {$urandom, $urandom};
    st[0][0] = st[0][1] ^ st[0][2];
    start[0] = 1'b1;
    run_layer(0, 1'b0, cyc, nb, nr);
    check("mkat_done_cycle", 64'(cyc), 64'd21);
    check("mkat_rnd_cycles", 64'(nr), 64'd16);
    check("mkat_result", res_w[0][0] ^ res_w[0][1] ^ res_w[0][2], 64'hCCCCCCCCCCCCCCCC);
    tick();

    // Starts in cycles 5 and 21 are ignored; a start in cycle 22 is taken
    mode[0] = 0;
    rand_state(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    cyc   = 1;
    ndone = 0;
    dcyc  = 0;
    while (cyc < 22) begin
      start[0] = (cyc == 5 || cyc == 21);
      tick();
      cyc++;
      start[0] = 1'b0;
      if (done_w[0]) begin
        ndone++;
        dcyc = cyc;
      end
    end
    check("ign_done_count", 64'(ndone), 64'd1);
    check("ign_done_cycle", 64'(dcyc), 64'd21);
    rand_state(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("restart_busy", 64'(busy_w[0]), 64'd1);
    check("restart_res1_cleared", res_w[0][0], 64'd0);
    run_layer(0, 1'b0, cyc, nb, nr);
    check("restart_done_cycle", 64'(cyc), 64'd20);
    tick();

    // Reset abort in cycle 10
    rand_state(0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    #1 rst_n = 1'b0;
    #1 check_zero(0, "abort");
    tick();
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (done_w[0]) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_res2", res_w[0][1], 64'd0);
    rand_state(0);
    start[0] = 1'b1;
    run_layer(0, 1'b0, cyc, nb, nr);
    check("post_abort_done_cycle", 64'(cyc), 64'd21);
    tick();

    // Latency sweep with delay-line S-boxes
    for (int g = 1; g < NI; g++) begin
      rand_state(g);
      t0 = st[g][0];
      t1 = st[g][1];
      t2 = st[g][2];
      start[g] = 1'b1;
      run_layer(g, 1'b0, cyc, nb, nr);
      check($sformatf("sweep_u%0d_done_cycle", g), 64'(cyc), 64'(17 + lat_of(g)));
      check($sformatf("sweep_u%0d_busy_cycles", g), 64'(nb), 64'(16 + lat_of(g)));
      check($sformatf("sweep_u%0d_rnd_cycles", g), 64'(nr), 64'd16);
      check($sformatf("sweep_u%0d_res1", g), res_w[g][0], t0);
      check($sformatf("sweep_u%0d_res2", g), res_w[g][1], t1);
      check($sformatf("sweep_u%0d_res3", g), res_w[g][2], t2);
      tick();
    end

    // Back-to-back layers with start held high
    mode[0]  = 0;
    start[0] = 1'b1;
    for (int l = 0; l < 3; l++) begin
      rand_state(0);
      t0 = st[0][0];
      t1 = st[0][1];
      t2 = st[0][2];
      run_layer(0, 1'b1, cyc, nb, nr);
      check($sformatf("b2b%0d_period", l), 64'(cyc), (l == 0) ? 64'd21 : 64'd22);
      check($sformatf("b2b%0d_res1", l), res_w[0][0], t0);
      check($sformatf("b2b%0d_res2", l), res_w[0][1], t1);
      check($sformatf("b2b%0d_res3", l), res_w[0][2], t2);
    end
    start[0] = 1'b0;
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/present_sbox_layer_ctrl.md
# present_sbox_layer_ctrl

Sequencer that runs the full PRESENT substitution layer of a 3-share, 64-bit masked state through a single shared second-order masked S-box pipeline. It issues one nibble (all three shares) per cycle, gates the 8-bit S-box randomness request, and reassembles the 16 returned nibbles into three 64-bit result shares. It sits between the round-state register and the masked S-box instance in the second-order PRESENT encryption core.

## Interface
- SBOX_LAT, 4, cycles from a nibble on sbox_in* to its result on sbox_out* (S-box pipeline depth)
- RND_OFS, 1, cycles from a nibble on sbox_in* to the cycle in which that nibble's randomness must be valid on sbox_r
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request to process one layer; sampled only in IDLE
- st1, st2, st3  in  64 each  input state shares; sampled on the accepted start edge
- rnd_in  in  8  fresh randomness from the PRNG
- rnd_req  out  1  PRNG advance request; rnd_in is consumed in the same cycle
- sbox_r  out  8  randomness to the S-box (rnd_in when rnd_req=1, else 0)
- sbox_in1, sbox_in2, sbox_in3  out  4 each  nibble shares to the S-box
- sbox_out1, sbox_out2, sbox_out3  in  4 each  nibble shares from the S-box
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse when results are complete
- res1, res2, res3  out  64 each  substituted state shares

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: busy=0. On start=1, load st1..st3 into three 64-bit shift registers, clear res1..res3 and both counters, go to FEED.
- FEED: 16 cycles; issue counter i=0..15. sbox_in* = bits [4i+3:4i] of the shares (nibble 0 = LSB first). Shift registers shift right by 4 each cycle. After i=15, go to DRAIN.
- Outside FEED, sbox_in* are driven 0.
- rnd_req=1 exactly in the 16 cycles that are RND_OFS cycles after each FEED cycle; otherwise 0, and sbox_r=0.
- Capture counter j=0..15 runs SBOX_LAT cycles behind the issue counter. In each capture cycle, sbox_out* are written into res* bits [4j+3:4j]. Other nibbles hold.
- DRAIN: waits until j=15 has been captured, then goes to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE. res* hold their value until the next accepted start.
- start while busy or in DONE is ignored, with no queuing.
- The block never alters share values. It only routes them, so the masking invariant is the S-box's responsibility.

## Timing
- Start accepted at edge E0. FEED occupies cycles 1..16 after E0, with nibble i on sbox_in* in cycle 1+i.
- Nibble i is captured at the end of cycle 1+i+SBOX_LAT. The last capture is in cycle 16+SBOX_LAT.
- done is high in cycle 17+SBOX_LAT; for the default this is cycle 21. busy is high in cycles 1..16+SBOX_LAT.
- The next start is accepted earliest in the cycle after done, giving a throughput of one layer per 18+SBOX_LAT cycles.
- rnd_req is high in cycles 1+RND_OFS .. 16+RND_OFS.
- Reset values: busy=0, done=0, rnd_req=0, sbox_r=0, sbox_in*=0, res*=0, state=IDLE, and all counters 0.
- rst_n low mid-operation aborts immediately. No done is produced, and after release the block is in IDLE with res*=0.
- SBOX_LAT range is 1..15 and RND_OFS range is 0..SBOX_LAT-1. Counters are 4-bit; capture is enabled by a delayed valid pipeline of SBOX_LAT bits, not by wrap-around of i.

## Test plan
- Unshared known-answer test: st1=0x0123456789ABCDEF, st2=st3=0, with an unmasked PRESENT S-box model at SBOX_LAT=4. Required result: res1^res2^res3=0xC56B90AD3EF84712, done in cycle 21, busy high in cycles 1..20.
- Masked known-answer test: st1^st2^st3=0 with random st2 and st3, using the real masked S-box instance. Required result: XOR of res*=0xCCCCCCCCCCCCCCCC. rnd_req is high for exactly 16 cycles (cycles 2..17), and sbox_r=0 whenever rnd_req=0.
- Ignored start: pulse start again in cycles 5 and 21. Both are ignored, with exactly one done. A start in cycle 22 begins a new layer, and res* is cleared in cycle 22.
- Reset abort: assert rst_n=0 in cycle 10. Required: all outputs 0 asynchronously, and no done afterwards. A fresh start then completes normally.
- Latency sweep: SBOX_LAT=1, 6 and 15 with a delay-line S-box model (out=in delayed). Required: res*=st*, done in cycle 17+SBOX_LAT.
- Back-to-back layers: hold start high continuously. Required: one layer every 22 cycles at the default, with each res* matching its own input.
